// File: rtl/coproc_instr_decoder_pkg.sv
// rtl/coproc_instr_decoder_pkg.sv - shared codes, field positions and helpers for the coprocessor decoder
// Purpose: op/mat codes, instruction field bit positions, bank geometry,
//          FSM state type, size->dim mapping and element index helper.
// Ports:   none (package)
package coproc_instr_decoder_pkg;

    localparam int DATA_W  = 8;
    localparam int MAX_DIM = 5;
    localparam int ELEMS   = MAX_DIM * MAX_DIM;
    localparam int INSTR_W = 22;

    localparam int OP_HI   = 21;
    localparam int OP_LO   = 20;
    localparam int DATA_HI = 19;
    localparam int DATA_LO = 12;
    localparam int MAT_HI  = 11;
    localparam int MAT_LO  = 10;
    localparam int ROW_HI  = 9;
    localparam int ROW_LO  = 7;
    localparam int COL_HI  = 6;
    localparam int COL_LO  = 4;
    localparam int SIZE_HI = 3;
    localparam int SIZE_LO = 0;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ILL   = 2'b01,
        OP_STORE = 2'b10,
        OP_SUM   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        MAT_A   = 2'b00,
        MAT_B   = 2'b01,
        MAT_C   = 2'b10,
        MAT_ILL = 2'b11
    } mat_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_MEM,
        S_SUM_RUN,
        S_DONE
    } state_e;

    // size 00..11 selects a 2x2..5x5 SUM window
    function automatic logic [2:0] size_to_dim(input logic [1:0] size);
        return {1'b0, size} + 3'd2;
    endfunction

    // Row-major flat index; out-of-range rows/cols only occur for words
    // already rejected as illegal, so truncation there is harmless.
    function automatic logic [4:0] elem_idx(input logic [2:0] row, input logic [2:0] col);
        logic [5:0] t;
        t = ({3'b000, row} * 6'd5) + {3'b000, col};
        return t[4:0];
    endfunction

endpackage

// File: rtl/coproc_instr_decoder_bank.sv
// rtl/coproc_instr_decoder_bank.sv - matrix banks A, B, C with one write port and registered reads
// Purpose: three MAX_DIM x MAX_DIM banks of DATA_W elements, cleared on reset.
// Ports:   i_clk, i_rst        clock, synchronous active-high reset
//          i_we, i_wmat, i_widx, i_wdata   write port (bank select, flat index, data)
//          i_ridx              shared read index for all three banks
//          o_rd_a/b/c          registered read data, one cycle after i_ridx
module coproc_instr_decoder_bank
    import coproc_instr_decoder_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [1:0]        i_wmat,
    input  logic [4:0]        i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [4:0]        i_ridx,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b,
    output logic [DATA_W-1:0] o_rd_c
);

    logic [DATA_W-1:0] r_mem [3][ELEMS];
    logic [DATA_W-1:0] r_rd_a;
    logic [DATA_W-1:0] r_rd_b;
    logic [DATA_W-1:0] r_rd_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int m = 0; m < 3; m++) begin
                for (int e = 0; e < ELEMS; e++) begin
                    r_mem[m][e] <= '0;
                end
            end
            r_rd_a <= '0;
            r_rd_b <= '0;
            r_rd_c <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_wmat][i_widx] <= i_wdata;
            end
            r_rd_a <= r_mem[0][i_ridx];
            r_rd_b <= r_mem[1][i_ridx];
            r_rd_c <= r_mem[2][i_ridx];
        end
    end

    assign o_rd_a = r_rd_a;
    assign o_rd_b = r_rd_b;
    assign o_rd_c = r_rd_c;

endmodule

// File: rtl/coproc_instr_decoder.sv
// rtl/coproc_instr_decoder.sv - instruction decoder and STORE/LOAD/SUM sequencer for the matrix coprocessor
// Purpose: accepts 22-bit words over valid/ready, checks legality, runs
//          STORE/LOAD against banks A/B/C or an element-wise C = A + B,
//          and returns one done pulse (with err/ovf) per accepted word.
// Ports:   i_clk, i_rst                  clock, synchronous active-high reset
//          i_instr, i_instr_valid        instruction word and its valid
//          o_instr_ready                 accept strobe (transfer = valid & ready)
//          o_result_data                 LOAD data or last SUM element
//          o_done, o_err, o_ovf          completion pulse and its status
//          o_busy                        instruction in flight
module coproc_instr_decoder
    import coproc_instr_decoder_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_instr_valid,
    output logic               o_instr_ready,
    output logic [DATA_W-1:0]  o_result_data,
    output logic               o_done,
    output logic               o_err,
    output logic               o_ovf,
    output logic               o_busy
);

    state_e              r_state;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_legal;
    logic                r_instr_ready;
    logic                r_done;
    logic                r_err;
    logic                r_ovf;
    logic [DATA_W-1:0]   r_result;
    logic [2:0]          r_rd_row;
    logic [2:0]          r_rd_col;
    logic                r_pv;
    logic                r_pv_last;
    logic [2:0]          r_pv_row;
    logic [2:0]          r_pv_col;

    op_e                 w_op;
    logic [DATA_W-1:0]   w_data;
    logic [1:0]          w_mat;
    logic [2:0]          w_row;
    logic [2:0]          w_col;
    logic [3:0]          w_size;
    logic [2:0]          w_dim_m1;
    logic                w_legal;
    logic                w_in_sum;
    logic                w_rd_last;
    logic                w_we;
    logic [1:0]          w_wmat;
    logic [4:0]          w_widx;
    logic [DATA_W-1:0]   w_wdata;
    logic [4:0]          w_ridx;
    logic [DATA_W-1:0]   w_rd_a;
    logic [DATA_W-1:0]   w_rd_b;
    logic [DATA_W-1:0]   w_rd_c;
    logic [DATA_W-1:0]   w_sum;
    logic                w_sum_ovf;
    logic [DATA_W-1:0]   w_load_data;

    assign w_op     = op_e'(r_instr[OP_HI:OP_LO]);
    assign w_data   = r_instr[DATA_HI:DATA_LO];
    assign w_mat    = r_instr[MAT_HI:MAT_LO];
    assign w_row    = r_instr[ROW_HI:ROW_LO];
    assign w_col    = r_instr[COL_HI:COL_LO];
    assign w_size   = r_instr[SIZE_HI:SIZE_LO];
    assign w_dim_m1 = size_to_dim(w_size[1:0]) - 3'd1;

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_STORE, OP_LOAD: w_legal = (w_mat != MAT_ILL)
                                      && (w_row < 3'(MAX_DIM))
                                      && (w_col < 3'(MAX_DIM));
            OP_SUM:            w_legal = (w_size[3:2] == 2'b00);
            default:           w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_load_data = w_rd_c;
        case (w_mat)
            MAT_A:   w_load_data = w_rd_a;
            MAT_B:   w_load_data = w_rd_b;
            default: w_load_data = w_rd_c;
        endcase
    end

    // Wrap adder; signed overflow when both operands share a sign the result lacks
    assign w_sum     = w_rd_a + w_rd_b;
    assign w_sum_ovf = (w_rd_a[DATA_W-1] == w_rd_b[DATA_W-1])
                    && (w_sum[DATA_W-1] != w_rd_a[DATA_W-1]);

    // During SUM the read index runs one element ahead of the C write
    // because bank reads land a cycle after the address is presented.
    assign w_in_sum  = (r_state == S_SUM_RUN);
    assign w_rd_last = (r_rd_row == w_dim_m1) && (r_rd_col == w_dim_m1);
    assign w_we      = w_in_sum ? r_pv
                                : ((r_state == S_MEM) && r_legal && (w_op == OP_STORE));
    assign w_wmat    = w_in_sum ? MAT_C : w_mat;
    assign w_widx    = w_in_sum ? elem_idx(r_pv_row, r_pv_col) : elem_idx(w_row, w_col);
    assign w_wdata   = w_in_sum ? w_sum : w_data;
    assign w_ridx    = w_in_sum ? elem_idx(r_rd_row, r_rd_col) : elem_idx(w_row, w_col);

    coproc_instr_decoder_bank u_bank (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_we),
        .i_wmat  (w_wmat),
        .i_widx  (w_widx),
        .i_wdata (w_wdata),
        .i_ridx  (w_ridx),
        .o_rd_a  (w_rd_a),
        .o_rd_b  (w_rd_b),
        .o_rd_c  (w_rd_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_instr       <= '0;
            r_legal       <= 1'b0;
            r_instr_ready <= 1'b1;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_ovf         <= 1'b0;
            r_result      <= '0;
            r_rd_row      <= '0;
            r_rd_col      <= '0;
            r_pv          <= 1'b0;
            r_pv_last     <= 1'b0;
            r_pv_row      <= '0;
            r_pv_col      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_instr_valid) begin
                        r_instr       <= i_instr;
                        r_instr_ready <= 1'b0;
                        r_ovf         <= 1'b0;
                        r_err         <= 1'b0;
                        r_state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_legal  <= w_legal;
                    r_rd_row <= '0;
                    r_rd_col <= '0;
                    r_pv     <= 1'b0;
                    // Illegal words also pass through the MEM slot (without touching
                    // the banks) so every non-SUM instruction has the same latency.
                    r_state  <= (w_legal && (w_op == OP_SUM)) ? S_SUM_RUN : S_MEM;
                end
                S_MEM: begin
                    if (r_legal && (w_op == OP_LOAD)) begin
                        r_result <= w_load_data;
                    end
                    r_err   <= ~r_legal;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_SUM_RUN: begin
                    if (r_pv && w_sum_ovf) begin
                        r_ovf <= 1'b1;
                    end
                    if (r_pv && r_pv_last) begin
                        r_result <= w_sum;
                        r_pv     <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_pv      <= 1'b1;
                        r_pv_row  <= r_rd_row;
                        r_pv_col  <= r_rd_col;
                        r_pv_last <= w_rd_last;
                        if (r_rd_col == w_dim_m1) begin
                            r_rd_col <= '0;
                            r_rd_row <= r_rd_row + 3'd1;
                        end else begin
                            r_rd_col <= r_rd_col + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_done        <= 1'b0;
                    r_err         <= 1'b0;
                    r_instr_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_instr_ready = r_instr_ready;
    assign o_busy        = ~r_instr_ready;
    assign o_result_data = r_result;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_ovf         = r_ovf;

endmodule

// File: tb/tb_coproc_instr_decoder.sv
// tb/tb_coproc_instr_decoder.sv - self-checking bench for coproc_instr_decoder
module tb_coproc_instr_decoder;

    logic        clk;
    logic        rst;
    logic [21:0] instr;
    logic        valid;
    logic        ready;
    logic [7:0]  rdata;
    logic        done;
    logic        err;
    logic        ovf;
    logic        busy;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [21:0] instr;
        logic        exp_err;
        logic        exp_ovf;
        logic [7:0]  exp_data;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    // Reference model: plain integer matrices indexed [mat][row][col]
    int m_bank[3][5][5];
    int m_result;

    coproc_instr_decoder dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instr       (instr),
        .i_instr_valid (valid),
        .o_instr_ready (ready),
        .o_result_data (rdata),
        .o_done        (done),
        .o_err         (err),
        .o_ovf         (ovf),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] mk(input logic [1:0] op, input logic [7:0] d,
                                       input logic [1:0] m, input logic [2:0] r,
                                       input logic [2:0] c, input logic [3:0] s);
        return {op, d, m, r, c, s};
    endfunction

    function automatic vec_t mkv(input logic [21:0] w, input logic e, input logic o,
                                 input logic [7:0] d, input int l);
        vec_t v;
        v.instr = w; v.exp_err = e; v.exp_ovf = o; v.exp_data = d; v.exp_lat = l;
        return v;
    endfunction

    function automatic int sx(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 3; m++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    m_bank[m][r][c] = 0;
        m_result = 0;
    endtask

    task automatic model_exec(input logic [21:0] w, output logic me, output logic mo, output int ml);
        int op, data, mat, row, col, size, dim, s;
        op = int'(w[21:20]); data = int'(w[19:12]); mat = int'(w[11:10]);
        row = int'(w[9:7]); col = int'(w[6:4]); size = int'(w[3:0]);
        me = 1'b0; mo = 1'b0; ml = 3;
        if (op == 2 || op == 0) begin
            if (mat == 3 || row > 4 || col > 4) me = 1'b1;
            else if (op == 2) m_bank[mat][row][col] = data;
            else m_result = m_bank[mat][row][col];
        end else if (op == 3) begin
            if (size > 3) me = 1'b1;
            else begin
                dim = size + 2;
                ml = 3 + dim * dim;
                for (int r = 0; r < dim; r++) begin
                    for (int c = 0; c < dim; c++) begin
                        s = sx(m_bank[0][r][c]) + sx(m_bank[1][r][c]);
                        if (s > 127 || s < -128) mo = 1'b1;
                        m_bank[2][r][c] = s & 255;
                        m_result = s & 255;
                    end
                end
            end
        end else begin
            me = 1'b1;
        end
    endtask

    // Present one word; lat counts posedges after the transfer edge T at which done is seen
    task automatic issue(input logic [21:0] w, output int lat, output logic e,
                         output logic o, output logic [7:0] d);
        lat = -1; e = 1'b0; o = 1'b0; d = 8'h00;
        @(negedge clk);
        chk("ready_in_idle", ready, 1);
        instr = w;
        valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            valid = 1'b0;
            if (k == 1) begin
                chk("ready_low_after_accept", ready, 0);
                chk("busy_after_accept", busy, 1);
            end
            if (done) begin
                lat = k; e = err; o = ovf; d = rdata;
                break;
            end
        end
        if (lat < 0) begin
            nchk++;
            nerr++;
            $display("FAIL done_timeout: no done within 60 cycles for instr 0x%0h", w);
        end else begin
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("ready_after_done", ready, 1);
        end
    endtask

    task automatic run_one(input string tag, input logic [21:0] w, input logic e_err,
                           input logic e_ovf, input logic [7:0] e_data, input int e_lat);
        int lat; logic e, o; logic [7:0] d;
        issue(w, lat, e, o, d);
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_err"}, e, e_err);
        chk({tag, "_ovf"}, o, e_ovf);
        chk({tag, "_data"}, d, e_data);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_data"}, rdata, 0);
    endtask

    initial begin
        logic me, mo;
        int ml, dcount;
        logic [21:0] w;

        // STORE=2, LOAD=0, SUM=3; mat A=0 B=1 C=2
        tbl.push_back(mkv(mk(2, 8'hFF, 0, 0, 0, 0), 0, 0, 8'h00, 3));
        tbl.push_back(mkv(mk(2, 8'hFF, 1, 0, 0, 0), 0, 0, 8'h00, 3));
        tbl.push_back(mkv(mk(3, 8'h00, 0, 0, 0, 0), 0, 0, 8'h00, 7));
        tbl.push_back(mkv(mk(0, 8'h00, 2, 0, 0, 0), 0, 0, 8'hFE, 3));
        tbl.push_back(mkv(mk(2, 8'h7F, 0, 1, 1, 0), 0, 0, 8'hFE, 3));
        tbl.push_back(mkv(mk(2, 8'h01, 1, 1, 1, 0), 0, 0, 8'hFE, 3));
        tbl.push_back(mkv(mk(3, 8'h00, 0, 0, 0, 0), 0, 1, 8'h80, 7));
        tbl.push_back(mkv(mk(0, 8'h00, 2, 1, 1, 0), 0, 0, 8'h80, 3));
        tbl.push_back(mkv(mk(2, 8'h05, 0, 4, 4, 0), 0, 0, 8'h80, 3));
        tbl.push_back(mkv(mk(3, 8'h00, 0, 0, 0, 0), 0, 1, 8'h80, 7));
        tbl.push_back(mkv(mk(0, 8'h00, 2, 4, 4, 0), 0, 0, 8'h00, 3));
        tbl.push_back(mkv(mk(2, 8'h03, 1, 4, 4, 0), 0, 0, 8'h00, 3));
        tbl.push_back(mkv(mk(3, 8'h00, 0, 0, 0, 3), 0, 1, 8'h08, 28));
        tbl.push_back(mkv(mk(0, 8'h00, 2, 4, 4, 0), 0, 0, 8'h08, 3));
        tbl.push_back(mkv(mk(1, 8'h44, 0, 0, 0, 0), 1, 0, 8'h08, 3));
        tbl.push_back(mkv(mk(2, 8'h66, 3, 0, 0, 0), 1, 0, 8'h08, 3));
        tbl.push_back(mkv(mk(2, 8'h55, 0, 5, 0, 0), 1, 0, 8'h08, 3));
        tbl.push_back(mkv(mk(2, 8'h55, 0, 0, 5, 0), 1, 0, 8'h08, 3));
        tbl.push_back(mkv(mk(3, 8'h00, 0, 0, 0, 4), 1, 0, 8'h08, 3));
        tbl.push_back(mkv(mk(0, 8'h00, 3, 0, 0, 0), 1, 0, 8'h08, 3));
        tbl.push_back(mkv(mk(0, 8'h00, 0, 1, 0, 0), 0, 0, 8'h00, 3));
        tbl.push_back(mkv(mk(0, 8'h00, 0, 0, 0, 0), 0, 0, 8'hFF, 3));
        tbl.push_back(mkv(mk(0, 8'h00, 2, 0, 0, 0), 0, 0, 8'hFE, 3));
        tbl.push_back(mkv(mk(0, 8'h00, 2, 1, 1, 0), 0, 0, 8'h80, 3));
        tbl.push_back(mkv(mk(0, 8'h00, 0, 4, 4, 0), 0, 0, 8'h05, 3));

        rst = 1'b1; valid = 1'b0; instr = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset");

        foreach (tbl[i]) begin
            model_exec(tbl[i].instr, me, mo, ml);
            run_one($sformatf("vec%0d", i), tbl[i].instr, tbl[i].exp_err,
                    tbl[i].exp_ovf, tbl[i].exp_data, tbl[i].exp_lat);
        end

        // Held valid: second acceptance only once back in IDLE
        @(negedge clk);
        w = mk(2, 8'h11, 0, 2, 2, 0);
        instr = w; valid = 1'b1;
        @(posedge clk);
        dcount = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 5) valid = 1'b0;
            chk($sformatf("hold_done_k%0d", k), done, (k == 3 || k == 7) ? 1 : 0);
            chk($sformatf("hold_ready_k%0d", k), ready, (k == 4 || k >= 8) ? 1 : 0);
            if (done) dcount++;
        end
        chk("hold_done_count", dcount, 2);
        model_exec(w, me, mo, ml);
        model_exec(w, me, mo, ml);
        run_one("hold_reload", mk(0, 8'h00, 0, 2, 2, 0), 0, 0, 8'h11, 3);
        model_exec(mk(0, 8'h00, 0, 2, 2, 0), me, mo, ml);

        // Randomized instructions against the model
        for (int i = 0; i < 80; i++) begin
            int sel;
            logic [1:0] op;
            sel = $urandom_range(0, 9);
            op = (sel <= 3) ? 2'd2 : (sel <= 6) ? 2'd0 : (sel <= 8) ? 2'd3 : 2'd1;
            w = mk(op, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)),
                   4'($urandom_range(0, 4)));
            model_exec(w, me, mo, ml);
            run_one($sformatf("rand%0d", i), w, me, mo, 8'(m_result), ml);
        end

        // Reset during the third SUM_RUN cycle drops the SUM with no done
        run_one("pre_rst_storeA", mk(2, 8'h10, 0, 0, 0, 0), 0, 0, 8'(m_result), 3);
        model_exec(mk(2, 8'h10, 0, 0, 0, 0), me, mo, ml);
        @(negedge clk);
        instr = mk(3, 8'h00, 0, 0, 0, 0); valid = 1'b1;
        @(posedge clk);
        @(negedge clk); valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_reset_outputs("mid_sum_reset");
        model_clear();
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("mid_sum_reset_no_done", dcount, 0);
        run_one("post_rst_loadC00", mk(0, 8'h00, 2, 0, 0, 0), 0, 0, 8'h00, 3);
        run_one("post_rst_loadA00", mk(0, 8'h00, 0, 0, 0, 0), 0, 0, 8'h00, 3);

        // Reset together with a valid word: nothing accepted
        @(negedge clk);
        rst = 1'b1; valid = 1'b1; instr = mk(2, 8'h77, 0, 3, 3, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        dcount = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("rst_valid_no_done", dcount, 0);
        run_one("rst_valid_loadA33", mk(0, 8'h00, 0, 3, 3, 0), 0, 0, 8'h00, 3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
